// File: rtl/trace_pkg.sv
// Shared definitions for the pipeline trace buffer.
//   trace_state_t : capture FSM states, encoded as reported on Out_State
//   CH_*          : channel index of each observed pipeline word inside a sample
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_t;

  localparam int unsigned CH_PC    = 0;
  localparam int unsigned CH_INSTR = 1;
  localparam int unsigned CH_ALU   = 2;
  localparam int unsigned CH_MEM   = 3;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port sample store: one write port, one synchronous read port.
//   clk    : clock, rising edge
//   wr_en  : write wdata at waddr
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address, captured every cycle
//   rdata  : read data, valid one cycle after raddr
module trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 128,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipeline_trace_buffer.sv
// On-chip trace capture for the MIPS pipeline observation ports.
// Samples CHANNELS words per valid cycle into a DEPTH-entry circular buffer,
// triggers on a PC match (channel 0), records POST_DEPTH further samples and
// then freezes for handshake readout.
//   Clk, Rst_n     : clock; synchronous active-low reset
//   In_Arm         : clear buffer and start capture (ARMED)
//   In_Valid       : sample strobe
//   In_Data        : packed sample, channel k at [k*DATA_W +: DATA_W]
//   In_TrigEn      : enable PC-match trigger
//   In_TrigPC      : trigger PC
//   In_RdEn        : read request, honoured only in DONE
//   In_RdAddr      : read index, 0 = oldest stored sample
//   Out_RdData     : read data (0 for indices beyond Out_Count)
//   Out_RdValid    : Out_RdData valid, one cycle after an honoured In_RdEn
//   Out_State      : 0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   Out_Count      : stored samples, saturating at DEPTH
//   Out_Wrapped    : buffer has wrapped since arm
//   Out_Triggered  : trigger sample seen since arm
module pipeline_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned POST_DEPTH = 8,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       In_Arm,
  input  logic                       In_Valid,
  input  logic [CHANNELS*DATA_W-1:0] In_Data,
  input  logic                       In_TrigEn,
  input  logic [DATA_W-1:0]          In_TrigPC,
  input  logic                       In_RdEn,
  input  logic [AW-1:0]              In_RdAddr,
  output logic [CHANNELS*DATA_W-1:0] Out_RdData,
  output logic                       Out_RdValid,
  output logic [1:0]                 Out_State,
  output logic [AW:0]                Out_Count,
  output logic                       Out_Wrapped,
  output logic                       Out_Triggered
);

  localparam int unsigned W         = CHANNELS * DATA_W;
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   POST_LAST = (AW+1)'(POST_DEPTH);
  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

  trace_state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   post_cnt_q;
  logic [AW:0]   post_cnt_inc;
  logic          wrapped_q;
  logic          triggered_q;
  logic          rd_valid_q;
  logic          rd_zero_q;

  logic          wr_en;
  logic          trig;
  logic          pc_match;
  logic          rd_ok;
  logic [AW-1:0] oldest;
  logic [AW-1:0] raddr;
  logic [W-1:0]  ram_q;

  assign pc_match     = In_TrigEn && (In_Data[CH_PC*DATA_W +: DATA_W] == In_TrigPC);
  assign post_cnt_inc = post_cnt_q + (AW+1)'(1);
  assign oldest       = wrapped_q ? wr_ptr_q : '0;
  // Logical index is rotated onto the physical slot so 0 is always the oldest sample.
  assign raddr        = oldest + In_RdAddr;
  assign rd_ok        = (state_q == ST_DONE) && In_RdEn && !In_Arm;

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    trig    = 1'b0;
    if (In_Arm) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (In_Valid) begin
            wr_en = 1'b1;
            if (pc_match) begin
              trig    = 1'b1;
              state_d = (POST_DEPTH == 0) ? ST_DONE : ST_POST;
            end
          end
        end
        ST_POST: begin
          if (In_Valid) begin
            wr_en = 1'b1;
            if (post_cnt_inc == POST_LAST) begin
              state_d = ST_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      post_cnt_q  <= '0;
      wrapped_q   <= 1'b0;
      triggered_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_zero_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_ok;
      // Output data is forced to zero when idle or out of range, so the
      // un-reset RAM output never leaks onto Out_RdData.
      rd_zero_q  <= !rd_ok || ({1'b0, In_RdAddr} >= count_q);
      if (In_Arm) begin
        wr_ptr_q    <= '0;
        count_q     <= '0;
        post_cnt_q  <= '0;
        wrapped_q   <= 1'b0;
        triggered_q <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
          if (count_q != DEPTH_CNT) begin
            count_q <= count_q + (AW+1)'(1);
          end
          if (wr_ptr_q == PTR_LAST) begin
            wrapped_q <= 1'b1;
          end
        end
        if (trig) begin
          triggered_q <= 1'b1;
          post_cnt_q  <= '0;
        end else if (wr_en && (state_q == ST_POST)) begin
          post_cnt_q <= post_cnt_inc;
        end
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_ram (
    .clk   (Clk),
    .wr_en (wr_en && Rst_n),
    .waddr (wr_ptr_q),
    .wdata (In_Data),
    .raddr (raddr),
    .rdata (ram_q)
  );

  assign Out_RdData    = rd_zero_q ? '0 : ram_q;
  assign Out_RdValid   = rd_valid_q;
  assign Out_State     = state_q;
  assign Out_Count     = count_q;
  assign Out_Wrapped   = wrapped_q;
  assign Out_Triggered = triggered_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
module tb_pipeline_trace_buffer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CH     = 4;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AW     = 3;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic              In_Arm;
  logic              In_Valid;
  logic [CH*DATA_W-1:0] In_Data;
  logic              In_TrigEn;
  logic [DATA_W-1:0] In_TrigPC;
  logic              In_RdEn;
  logic [AW-1:0]     In_RdAddr;
  logic [CH*DATA_W-1:0] Out_RdData;
  logic              Out_RdValid;
  logic [1:0]        Out_State;
  logic [AW:0]       Out_Count;
  logic              Out_Wrapped;
  logic              Out_Triggered;

  int checks = 0;
  int errors = 0;

  pipeline_trace_buffer #(
    .DATA_W     (DATA_W),
    .CHANNELS   (CH),
    .DEPTH      (DEPTH),
    .POST_DEPTH (3)
  ) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .In_Arm        (In_Arm),
    .In_Valid      (In_Valid),
    .In_Data       (In_Data),
    .In_TrigEn     (In_TrigEn),
    .In_TrigPC     (In_TrigPC),
    .In_RdEn       (In_RdEn),
    .In_RdAddr     (In_RdAddr),
    .Out_RdData    (Out_RdData),
    .Out_RdValid   (Out_RdValid),
    .Out_State     (Out_State),
    .Out_Count     (Out_Count),
    .Out_Wrapped   (Out_Wrapped),
    .Out_Triggered (Out_Triggered)
  );

  always #5 Clk = ~Clk;

  // Sample word for a given PC: distinct value on every channel.
  function automatic logic [CH*DATA_W-1:0] mk(input logic [31:0] pc);
    return {pc + 32'h3000_0000, pc + 32'h2000_0000, pc + 32'h1000_0000, pc};
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic arm();
    In_Arm = 1'b1;
    step();
    In_Arm = 1'b0;
  endtask

  task automatic feed(input logic [31:0] pc);
    In_Valid = 1'b1;
    In_Data  = mk(pc);
    step();
    In_Valid = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    step();
    step();
    Rst_n = 1'b1;
    checks++; if (Out_State !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", Out_State); end
    checks++; if (Out_Count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", Out_Count); end
    checks++; if (Out_Wrapped !== 1'b0 || Out_Triggered !== 1'b0) begin errors++; $display("FAIL rst_flags got w=%b t=%b exp 0 0", Out_Wrapped, Out_Triggered); end
    checks++; if (Out_RdValid !== 1'b0 || Out_RdData !== '0) begin errors++; $display("FAIL rst_rd got v=%b d=%h exp 0 0", Out_RdValid, Out_RdData); end
    feed(32'h0);
    checks++; if (Out_State !== 2'd0 || Out_Count !== 4'd0) begin errors++; $display("FAIL idle_ignore got st=%0d cnt=%0d exp 0 0", Out_State, Out_Count); end
  endtask

  task automatic test_wrap_trigger();
    In_TrigEn = 1'b1;
    In_TrigPC = 32'h20;
    arm();
    checks++; if (Out_State !== 2'd1) begin errors++; $display("FAIL t1_armed got %0d exp 1", Out_State); end
    for (int i = 0; i < 12; i++) begin
      feed(32'(i * 4));
      if (i == 8) begin
        checks++; if (Out_State !== 2'd2 || Out_Triggered !== 1'b1) begin errors++; $display("FAIL t1_post got st=%0d trg=%b exp 2 1", Out_State, Out_Triggered); end
      end
    end
    checks++; if (Out_State !== 2'd3) begin errors++; $display("FAIL t1_done got %0d exp 3", Out_State); end
    checks++; if (Out_Count !== 4'd8) begin errors++; $display("FAIL t1_count got %0d exp 8", Out_Count); end
    checks++; if (Out_Wrapped !== 1'b1) begin errors++; $display("FAIL t1_wrapped got %b exp 1", Out_Wrapped); end
    In_RdEn = 1'b1; In_RdAddr = 3'd0;
    step();
    checks++; if (Out_RdValid !== 1'b1 || Out_RdData !== mk(32'h10)) begin errors++; $display("FAIL t1_rd0 got v=%b d=%h exp 1 %h", Out_RdValid, Out_RdData, mk(32'h10)); end
    In_RdAddr = 3'd7;
    step();
    checks++; if (Out_RdValid !== 1'b1 || Out_RdData !== mk(32'h2C)) begin errors++; $display("FAIL t1_rd7 got v=%b d=%h exp 1 %h", Out_RdValid, Out_RdData, mk(32'h2C)); end
    In_RdEn = 1'b0;
    step();
    checks++; if (Out_RdValid !== 1'b0) begin errors++; $display("FAIL t1_rd_idle got %b exp 0", Out_RdValid); end
  endtask

  task automatic test_no_wrap();
    In_TrigPC = 32'h08;
    arm();
    for (int i = 0; i < 6; i++) feed(32'(i * 4));
    checks++; if (Out_State !== 2'd3 || Out_Count !== 4'd6 || Out_Wrapped !== 1'b0) begin errors++; $display("FAIL t2_done got st=%0d cnt=%0d w=%b exp 3 6 0", Out_State, Out_Count, Out_Wrapped); end
    In_RdEn = 1'b1; In_RdAddr = 3'd0;
    step();
    checks++; if (Out_RdValid !== 1'b1 || Out_RdData !== mk(32'h0)) begin errors++; $display("FAIL t2_rd0 got v=%b d=%h exp 1 %h", Out_RdValid, Out_RdData, mk(32'h0)); end
    In_RdAddr = 3'd5;
    step();
    checks++; if (Out_RdValid !== 1'b1 || Out_RdData !== mk(32'h14)) begin errors++; $display("FAIL t2_rd5 got v=%b d=%h exp 1 %h", Out_RdValid, Out_RdData, mk(32'h14)); end
    In_RdAddr = 3'd6;
    step();
    checks++; if (Out_RdValid !== 1'b1 || Out_RdData !== '0) begin errors++; $display("FAIL t2_rd6 got v=%b d=%h exp 1 0", Out_RdValid, Out_RdData); end
    In_RdEn = 1'b0;
    step();
  endtask

  task automatic test_gapped_valid();
    In_TrigPC = 32'h08;
    arm();
    for (int c = 0; c <= 10; c++) begin
      if (c % 2 == 0) begin
        feed(32'(c * 2));
      end else begin
        In_Valid = 1'b0;
        In_Data  = mk(32'h08);
        step();
      end
      if (c == 9) begin
        checks++; if (Out_State !== 2'd2) begin errors++; $display("FAIL t3_post9 got %0d exp 2", Out_State); end
      end
    end
    checks++; if (Out_State !== 2'd3 || Out_Count !== 4'd6) begin errors++; $display("FAIL t3_done got st=%0d cnt=%0d exp 3 6", Out_State, Out_Count); end
    In_RdEn = 1'b1;
    for (int a = 0; a < 6; a++) begin
      In_RdAddr = 3'(a);
      step();
      checks++; if (Out_RdValid !== 1'b1 || Out_RdData !== mk(32'(a * 4))) begin errors++; $display("FAIL t3_rd%0d got v=%b d=%h exp 1 %h", a, Out_RdValid, Out_RdData, mk(32'(a * 4))); end
    end
    In_RdEn = 1'b0;
    step();
  endtask

  task automatic test_rearm_in_done();
    In_TrigPC = 32'h104;
    In_Arm   = 1'b1;
    In_Valid = 1'b1;
    In_Data  = mk(32'h100);
    step();
    In_Arm = 1'b0;
    checks++; if (Out_State !== 2'd1 || Out_Count !== 4'd0 || Out_Triggered !== 1'b0) begin errors++; $display("FAIL t5_rearm got st=%0d cnt=%0d trg=%b exp 1 0 0", Out_State, Out_Count, Out_Triggered); end
    feed(32'h104);
    feed(32'h108);
    feed(32'h10C);
    feed(32'h110);
    checks++; if (Out_State !== 2'd3 || Out_Count !== 4'd4) begin errors++; $display("FAIL t5_done got st=%0d cnt=%0d exp 3 4", Out_State, Out_Count); end
    In_RdEn = 1'b1; In_RdAddr = 3'd0;
    step();
    In_RdEn = 1'b0;
    checks++; if (Out_RdValid !== 1'b1 || Out_RdData !== mk(32'h104)) begin errors++; $display("FAIL t5_rd0 got v=%b d=%h exp 1 %h", Out_RdValid, Out_RdData, mk(32'h104)); end
    step();
  endtask

  task automatic test_reset_in_post();
    In_TrigPC = 32'h08;
    arm();
    for (int i = 0; i < 4; i++) feed(32'(i * 4));
    checks++; if (Out_State !== 2'd2) begin errors++; $display("FAIL t4_post got %0d exp 2", Out_State); end
    Rst_n = 1'b0;
    In_Valid = 1'b1;
    In_Data = mk(32'h10);
    step();
    Rst_n = 1'b1;
    In_Valid = 1'b0;
    checks++; if (Out_State !== 2'd0 || Out_Count !== 4'd0 || Out_Triggered !== 1'b0 || Out_Wrapped !== 1'b0) begin errors++; $display("FAIL t4_rst got st=%0d cnt=%0d trg=%b w=%b exp 0 0 0 0", Out_State, Out_Count, Out_Triggered, Out_Wrapped); end
    In_RdEn = 1'b1; In_RdAddr = 3'd0;
    step();
    In_RdEn = 1'b0;
    checks++; if (Out_RdValid !== 1'b0) begin errors++; $display("FAIL t4_rd got %b exp 0", Out_RdValid); end
  endtask

  task automatic test_free_run();
    In_TrigEn = 1'b0;
    In_TrigPC = 32'h08;
    arm();
    for (int i = 0; i < 20; i++) feed(32'(i * 4));
    checks++; if (Out_State !== 2'd1 || Out_Count !== 4'd8 || Out_Wrapped !== 1'b1) begin errors++; $display("FAIL t6_run got st=%0d cnt=%0d w=%b exp 1 8 1", Out_State, Out_Count, Out_Wrapped); end
    checks++; if (Out_Triggered !== 1'b0) begin errors++; $display("FAIL t6_trg got %b exp 0", Out_Triggered); end
    In_RdEn = 1'b1; In_RdAddr = 3'd0;
    step();
    In_RdEn = 1'b0;
    checks++; if (Out_RdValid !== 1'b0) begin errors++; $display("FAIL t6_rd got %b exp 0", Out_RdValid); end
  endtask

  initial begin
    Rst_n     = 1'b0;
    In_Arm    = 1'b0;
    In_Valid  = 1'b0;
    In_Data   = '0;
    In_TrigEn = 1'b0;
    In_TrigPC = '0;
    In_RdEn   = 1'b0;
    In_RdAddr = '0;
    test_reset();
    test_wrap_trigger();
    test_no_wrap();
    test_gapped_valid();
    test_rearm_in_done();
    test_reset_in_post();
    test_free_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
